// File: rtl/encoder_pkg.sv
// Shared constants, FSM state type and debug view for the sequential 4-to-2 encoder.
package encoder_pkg;
  localparam int N_LINES = 4;
  localparam int CODE_W  = 2;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  // Internal state exposed for checkers; ptr stays 2'b11 when round-robin is off.
  typedef struct packed {
    state_t              state;
    logic [N_LINES-1:0]  pending;
    logic [CODE_W-1:0]   ptr;
  } dbg_t;
endpackage

// File: rtl/encoder_4to2_seq_prio_sel.sv
// Combinational selector: first set bit of mask strictly after ptr, wrapping 3 to 0.
// With ptr = 2'b11 this is plain fixed priority (index 0 highest).
module prio_sel
  import encoder_pkg::*;
(
  input  logic [N_LINES-1:0] mask,
  input  logic [CODE_W-1:0]  ptr,
  output logic [CODE_W-1:0]  index,
  output logic               any_set
);

  logic [CODE_W-1:0] cand;

  always_comb begin
    index   = '0;
    cand    = '0;
    any_set = |mask;
    // Scan farthest-to-nearest so the candidate closest after ptr wins.
    for (int k = N_LINES; k >= 1; k--) begin
      cand = ptr + CODE_W'(k);
      if (mask[cand]) index = cand;
    end
  end

endmodule

// File: rtl/encoder_4to2_seq.sv
// Sequential 4-to-2 encoder: captures a batch of active-low requests and emits their
// codes one per valid/ready handshake. Define ENCODER_RR_EN for round-robin selection.
//
// Handshake: out_valid is high exactly while in EMIT; a code transfers on any rising
// edge where out_valid && out_ready; Y/last/pending hold while out_ready is low.
module encoder_4to2_seq
  import encoder_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [N_LINES-1:0] D_n,
  input  logic               E_n,
  output logic [CODE_W-1:0]  Y,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               last,
  output logic               busy,
  output dbg_t               dbg
);

  state_t             state, state_next;
  logic [N_LINES-1:0] pending, pending_next;
  logic [CODE_W-1:0]  ptr;
  logic [CODE_W-1:0]  index;
  logic               any_set;
  logic               hs;

  prio_sel u_prio_sel (
    .mask    (pending),
    .ptr     (ptr),
    .index   (index),
    .any_set (any_set)
  );

  assign out_valid = (state == EMIT);
  assign hs        = out_valid && out_ready && any_set;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      pending <= '0;
    end else begin
      state   <= state_next;
      pending <= pending_next;
    end
  end

  always_comb begin
    state_next   = state;
    pending_next = pending;
    case (state)
      IDLE: begin
        if (!E_n && (~D_n != '0)) begin
          pending_next = ~D_n;
          state_next   = EMIT;
        end
      end
      EMIT: begin
        if (hs) begin
          pending_next = pending & ~(N_LINES'(1) << index);
          if (pending_next == '0) state_next = IDLE;
        end
      end
      default: begin
        state_next   = IDLE;
        pending_next = '0;
      end
    endcase
  end

`ifdef ENCODER_RR_EN
  // Pointer survives across batches so service rotates between captures too.
  logic [CODE_W-1:0] ptr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     ptr_q <= 2'b11;
    else if (hs) ptr_q <= index;
  end

  assign ptr = ptr_q;
`else
  assign ptr = 2'b11;
`endif

  assign Y    = out_valid ? index : '0;
  assign last = out_valid && $onehot(pending);
  assign busy = out_valid;

  assign dbg.state   = state;
  assign dbg.pending = pending;
  assign dbg.ptr     = ptr;

endmodule

// File: tb/tb_encoder_4to2_seq.sv
// Self-checking bench for encoder_4to2_seq: vector table, hand-written corner sequences
// and a code scoreboard fed by a reference model of the selection order.
module tb_encoder_4to2_seq;
  import encoder_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  D_n;
  logic        E_n;
  logic [1:0]  Y;
  logic        out_valid;
  logic        out_ready;
  logic        last;
  logic        busy;
  dbg_t        dbg;

  int          checks   = 0;
  int          failures = 0;
  int          hs_count = 0;
  logic [2:0]  exp_q[$];
  logic [2:0]  mon_exp;
  logic [1:0]  model_ptr;

  typedef struct {
    logic [3:0] d_n;
    logic       e_n;
    int         n;
  } vec_t;

  vec_t vecs[9];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  encoder_4to2_seq dut (
    .clk       (clk),
    .rst       (rst),
    .D_n       (D_n),
    .E_n       (E_n),
    .Y         (Y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .last      (last),
    .busy      (busy),
    .dbg       (dbg)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference order: fixed priority, or first set index after the last grant.
  task automatic push_model(input logic [3:0] mask_in);
    logic [3:0] m;
    logic [1:0] idx;
    m = mask_in;
    while (m != 4'b0000) begin
`ifdef ENCODER_RR_EN
      idx = model_ptr;
      do idx = idx + 2'd1; while (!m[idx]);
`else
      idx = 2'd0;
      while (!m[idx]) idx = idx + 2'd1;
`endif
      exp_q.push_back({($countones(m) == 1), idx});
      m[idx]    = 1'b0;
      model_ptr = idx;
    end
  endtask

  task automatic do_reset;
    rst       = 1'b1;
    E_n       = 1'b1;
    D_n       = 4'hF;
    out_ready = 1'b0;
    tick;
    tick;
    exp_q.delete();
    model_ptr = 2'b11;
    rst       = 1'b0;
    tick;
  endtask

  // Capture one batch, then drain it under random backpressure and random EMIT-time inputs.
  task automatic run_batch(input logic [3:0] d_n, input logic e_n, input int exp_n);
    int start;
    int n;
    start     = hs_count;
    E_n       = e_n;
    D_n       = d_n;
    out_ready = 1'b0;
    tick;
    if (exp_n > 0) push_model(~d_n);
    check("capture_valid", out_valid, (exp_n > 0));
    n = 0;
    while (out_valid && n < 100) begin
      out_ready = 1'($urandom_range(0, 1));
      E_n       = 1'($urandom_range(0, 1));
      D_n       = 4'($urandom_range(0, 15));
      tick;
      n++;
    end
    E_n       = 1'b1;
    D_n       = 4'hF;
    out_ready = 1'b0;
    if (n >= 100) begin
      checks++;
      failures++;
      $display("FAIL batch_timeout: out_valid still %0b after %0d cycles", out_valid, n);
    end
    check("handshakes", hs_count - start, exp_n);
    check("queue_drained", exp_q.size(), 0);
    check("idle_busy", busy, 0);
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      hs_count++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_code: got Y=%0d last=%0b with nothing expected", Y, last);
      end else begin
        mon_exp = exp_q.pop_front();
        check("code_last_y", {29'd0, last, Y}, {29'd0, mon_exp});
      end
    end
  end

  // ---------------- test ----------------
  initial begin
    int base;
    vecs[0] = '{4'b1011, 1'b0, 1};
    vecs[1] = '{4'b0101, 1'b0, 2};
    vecs[2] = '{4'b0000, 1'b0, 4};
    vecs[3] = '{4'b1111, 1'b0, 0};
    vecs[4] = '{4'b0000, 1'b1, 0};
    vecs[5] = '{4'b0110, 1'b0, 2};
    vecs[6] = '{4'b1110, 1'b0, 1};
    vecs[7] = '{4'b0111, 1'b0, 1};
    vecs[8] = '{4'b1000, 1'b0, 3};

    // Reset state, observed while rst is held.
    rst = 1'b1; E_n = 1'b0; D_n = 4'b0000; out_ready = 1'b1; model_ptr = 2'b11;
    tick;
    check("rst_valid", out_valid, 0);
    check("rst_y", Y, 0);
    check("rst_last", last, 0);
    check("rst_busy", busy, 0);
    check("rst_pending", dbg.pending, 0);
    do_reset;

    foreach (vecs[i]) run_batch(vecs[i].d_n, vecs[i].e_n, vecs[i].n);

    // Single line, latency 1, back to IDLE after one handshake.
    do_reset;
    E_n = 1'b0; D_n = 4'b1011; out_ready = 1'b1;
    tick;
    push_model(4'b0100);
    check("single_valid", out_valid, 1);
    check("single_y", Y, 2);
    check("single_last", last, 1);
    tick;
    check("single_idle_valid", out_valid, 0);
    check("single_idle_state", dbg.state, IDLE);
    // Inputs still requesting: recapture only after a cycle in IDLE.
    tick;
    push_model(4'b0100);
    check("recapture_valid", out_valid, 1);
    tick;
    check("no_b2b_capture", out_valid, 0);
    tick;
    push_model(4'b0100);
    check("recapture2_valid", out_valid, 1);
    E_n = 1'b1; D_n = 4'hF;
    tick;
    check("recapture2_done", out_valid, 0);

    // Two-line batch in index order.
    do_reset;
    base = hs_count;
    E_n = 1'b0; D_n = 4'b0101; out_ready = 1'b1;
    tick;
    push_model(4'b1010);
    E_n = 1'b1; D_n = 4'hF;
    check("multi_y0", Y, 1);
    check("multi_last0", last, 0);
    tick;
    check("multi_y1", Y, 3);
    check("multi_last1", last, 1);
    tick;
    check("multi_done", out_valid, 0);
    check("multi_hs", hs_count - base, 2);

    // Backpressure holds Y, last and pending.
    do_reset;
    E_n = 1'b0; D_n = 4'b1100; out_ready = 1'b0;
    tick;
    push_model(4'b0011);
    E_n = 1'b0; D_n = 4'b0000;
    for (int c = 0; c < 4; c++) begin
      check("bp_y", Y, 0);
      check("bp_last", last, 0);
      check("bp_pending", dbg.pending, 4'b0011);
      if (c < 3) tick;
    end
    out_ready = 1'b1;
    tick;
    check("bp_y_next", Y, 1);
    check("bp_last_next", last, 1);
    E_n = 1'b1; D_n = 4'hF;
    tick;
    check("bp_done", out_valid, 0);

    // Disabled, then enabled with no requests.
    do_reset;
    E_n = 1'b1; D_n = 4'b0000;
    tick;
    check("disabled_valid", out_valid, 0);
    check("disabled_state", dbg.state, IDLE);
    E_n = 1'b0; D_n = 4'b1111;
    tick;
    tick;
    check("empty_valid", out_valid, 0);
    check("empty_busy", busy, 0);

    // Reset in the middle of a batch drops the remaining codes.
    do_reset;
    E_n = 1'b0; D_n = 4'b0000; out_ready = 1'b1;
    tick;
    push_model(4'b1111);
    E_n = 1'b1; D_n = 4'hF;
    check("abort_y0", Y, 0);
    tick;
    check("abort_y1", Y, 1);
    #2 rst = 1'b1;
    #1;
    check("abort_valid", out_valid, 0);
    check("abort_pending", dbg.pending, 0);
    check("abort_busy", busy, 0);
    check("abort_y", Y, 0);
    exp_q.delete();
    model_ptr = 2'b11;
    base = hs_count;
    tick;
    rst = 1'b0;
    repeat (5) tick;
    check("abort_no_codes", hs_count - base, 0);
    check("abort_idle", out_valid, 0);

    // Selection order across batches: 0 then {1,0} with round-robin, {0,1} without.
    do_reset;
    run_batch(4'b1110, 1'b0, 1);
    E_n = 1'b0; D_n = 4'b1100; out_ready = 1'b1;
    tick;
    push_model(4'b0011);
    E_n = 1'b1; D_n = 4'hF;
`ifdef ENCODER_RR_EN
    check("order_first", Y, 1);
    tick;
    check("order_second", Y, 0);
`else
    check("order_first", Y, 0);
    tick;
    check("order_second", Y, 1);
`endif
    check("order_second_last", last, 1);
    tick;
    check("order_done", out_valid, 0);

    // Random batches.
    for (int r = 0; r < 20; r++) begin
      logic [3:0] d;
      logic       e;
      d = 4'($urandom_range(0, 15));
      e = ($urandom_range(0, 3) == 0);
      run_batch(d, e, e ? 0 : $countones(~d));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
